// File: rtl/seq_argmax_pkg.sv
// -----------------------------------------------------------------------------
// seq_argmax_pkg
//   Definitions shared by the sequential classifier layers:
//   - sum_width(m): bits needed to hold a popcount in 0..m
//   - idx_width(c): bits needed to index c classes (at least 1)
//   - state_e     : IDLE/SCAN encoding used by the sequential scanners
// -----------------------------------------------------------------------------
package seq_argmax_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  function automatic int sum_width(input int m);
    return $clog2(m + 1);
  endfunction

  function automatic int idx_width(input int c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction

endpackage : seq_argmax_pkg

// File: rtl/seq_argmax_if.sv
// -----------------------------------------------------------------------------
// seq_argmax_if
//   Start/done handshake and result bus of the argmax stage.
//   Signals:
//     start     : one-cycle request pulse, sums valid in the same cycle
//     sums      : packed class sums, class i at [i*SUML +: SUML]
//     busy      : scan in progress
//     done      : one-cycle pulse, class_idx/max_val just updated
//     class_idx : index of the maximum sum
//     max_val   : value of the maximum sum
//   Modports:
//     master : the requester (drives start/sums)
//     slave  : the argmax stage
// -----------------------------------------------------------------------------
interface seq_argmax_if
  import seq_argmax_pkg::*;
#(
  parameter int C = 4,
  parameter int M = 4
);

  localparam int SUML = sum_width(M);
  localparam int IDXW = idx_width(C);

  logic                 start;
  logic [SUML*C-1:0]    sums;
  logic                 busy;
  logic                 done;
  logic [IDXW-1:0]      class_idx;
  logic [SUML-1:0]      max_val;

  modport master (
    output start, sums,
    input  busy, done, class_idx, max_val
  );

  modport slave (
    input  start, sums,
    output busy, done, class_idx, max_val
  );

endinterface : seq_argmax_if

// File: rtl/seq_argmax.sv
// -----------------------------------------------------------------------------
// seq_argmax
//   Classifier output stage. On start, snapshots the packed per-class popcount
//   sums and scans them one class per cycle with a single comparator, then
//   pulses done with the winning class index and its score.
//   Latency: start in cycle 0 -> done in cycle C; busy high in cycles 1..C-1.
//   Ties resolve to the lowest index (strict compare).
//   Ports:
//     clk : system clock, rising edge
//     rst : asynchronous active-low reset
//     bus : seq_argmax_if.slave (start, sums, busy, done, class_idx, max_val)
// -----------------------------------------------------------------------------
module seq_argmax
  import seq_argmax_pkg::*;
#(
  parameter int C = 4,
  parameter int M = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_argmax_if.slave   bus
);

  localparam int SUML = sum_width(M);
  localparam int IDXW = idx_width(C);

  state_e              r_state;
  logic [SUML*C-1:0]   r_shadow;
  logic [SUML-1:0]     r_best_val;
  logic [IDXW-1:0]     r_best_idx;
  logic [IDXW-1:0]     r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [IDXW-1:0]     r_class_idx;
  logic [SUML-1:0]     r_max_val;

  logic [SUML-1:0]     w_cur;
  logic                w_better;
  logic                w_last;

  // Select the class currently under test from the shadow copy.
  always_comb begin
    // NOTE: default first so every path assigns w_cur and no latch is inferred.
    w_cur = '0;
    for (int i = 0; i < C; i++) begin
      if (r_cnt == IDXW'(i)) w_cur = r_shadow[i*SUML +: SUML];
    end
  end

  assign w_better = (w_cur > r_best_val);
  assign w_last   = (r_cnt == IDXW'(C - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      // NOTE: the shadow register is small flops, not RAM, so it is cleared
      // with the rest of the state; a mid-scan reset leaves nothing stale.
      r_shadow    <= '0;
      r_best_val  <= '0;
      r_best_idx  <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_class_idx <= '0;
      r_max_val   <= '0;
    end else begin
      // NOTE: non-blocking throughout so every branch sees pre-edge values.
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_shadow   <= bus.sums;
            r_best_val <= bus.sums[SUML-1:0];
            r_best_idx <= '0;
            r_cnt      <= IDXW'(1);
            if (C == 1) begin
              // Single class: the answer is known at the start edge.
              r_done      <= 1'b1;
              r_class_idx <= '0;
              r_max_val   <= bus.sums[SUML-1:0];
            end else begin
              r_state <= ST_SCAN;
              r_busy  <= 1'b1;
            end
          end
        end

        ST_SCAN: begin
          // start is not looked at here, so a request while busy is dropped.
          if (w_better) begin
            r_best_val <= w_cur;
            r_best_idx <= r_cnt;
          end
          if (w_last) begin
            // Publish the result including this cycle's compare.
            r_class_idx <= w_better ? r_cnt : r_best_idx;
            r_max_val   <= w_better ? w_cur : r_best_val;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + IDXW'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.class_idx = r_class_idx;
  assign bus.max_val   = r_max_val;

endmodule : seq_argmax

// File: doc/seq_argmax.md
Name: seq_argmax

Overview:
- Classifier output stage, directly downstream of the two-layer sequential BNN.
- Consumes the packed per-class popcount sums produced by the xnor layer.
- Scans them one class per cycle and reports the winning class index and its score, with a start/done handshake.
- Trades C cycles of latency for a single comparator, in keeping with the sequential flavour of the pipeline.

Parameters:
- C, 4, number of classes (C >= 1).
- M, 4, neurons in the hidden layer; sets the maximum popcount per class.
- SumL, $clog2(M+1), localparam; width of one class sum.
- IDXW, (C>1) ? $clog2(C) : 1, localparam; width of the class index.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; sums valid in this cycle.
- sums  input  SumL*C  packed class sums; class i occupies bits [i*SumL +: SumL], class 0 at LSBs.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse; result updated.
- class_idx  output  IDXW  index of the maximum sum.
- max_val  output  SumL  value of the maximum sum.

Behaviour:
- Reset: while rst=0, asynchronously clear state to IDLE and set busy=0, done=0, class_idx=0, max_val=0. Clear the internal shadow register and counters as well.
- States:
  - IDLE: busy=0.
  - SCAN: busy=1.
  - done is a registered pulse, not a state.
- IDLE, start=1 at cycle 0:
  - At the edge, copy sums into a shadow register. Later changes on sums are ignored.
  - Set best_val to sum[0], best_idx to 0, cnt to 1.
  - If C>1, go to SCAN. If C==1, finish immediately: done=1 in cycle 1, class_idx=0, max_val=sum[0].
- SCAN, each edge:
  - Compare shadow[cnt] > best_val, strictly. On true, set best_val to shadow[cnt] and best_idx to cnt.
  - When cnt==C-1: load class_idx/max_val from the final best (including this compare), set done=1 for one cycle, return to IDLE. Otherwise increment cnt.
- Latency: start in cycle 0 gives done=1 in cycle C. busy=1 in cycles 1..C-1.
- Tie rule: the lowest index wins, because the compare is strict.
- class_idx and max_val change only on the edge that raises done. They hold their value during scans and in IDLE.
- Unsigned compare, SumL bits. No overflow is possible.
- start while busy=1: ignored, with no effect on the scan in progress.
- start in the done cycle (state is IDLE): accepted, giving back-to-back operation. The next done comes C cycles later.
- Reset mid-scan: the scan is aborted, no done pulse is emitted, and outputs return to reset values.
- cnt width is IDXW. It never exceeds C-1, so there is no wrap.

Decomposition:
- Shared package: function clog2-based width helpers (SumL from M, IDXW from C) and the IDLE/SCAN state encoding, shared with other sequential layers.
- No sub-module. The slice mux plus one comparator is small enough to stay inline.

Test Plan (C=4, M=4, SumL=3; sums listed as {c3,c2,c1,c0}):
- Basic: reset, then start with {2,4,1,3} -> done in cycle 4, class_idx=2, max_val=4. busy=1 in cycles 1-3.
- Tie: {4,1,4,0} -> class_idx=1, max_val=4. All-zero {0,0,0,0} -> class_idx=0, max_val=0.
- Input isolation: start with {0,0,0,3}, then drive {4,4,4,4} during the scan -> class_idx=0, max_val=3. A start pulse in cycle 2 is ignored: exactly one done.
- Back-to-back: {1,0,0,0} then start in the done cycle with {0,0,4,0} -> first done gives idx 3/val 1. Second done, 4 cycles later, gives idx 1/val 4.
- Reset mid-scan: rst=0 in cycle 2 -> busy/done/class_idx/max_val all 0 immediately, and no done pulse follows. A new start after release works normally.
- C=1 build: start with sums=5 (M=5) -> done in cycle 1, class_idx=0, max_val=5. busy never asserted.
